// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg_scan_ctrl : 7-segment scan multiplexer with blanking gaps and           |
// | frame-boundary content commit. Optional blink via macro BLINK_EN.           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 6,
   parameter int DWELL_CYC    = 1000,
   parameter int BLANK_CYC    = 16,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   digits_in,
`ifdef BLINK_EN
   input  logic [NUM_DIGITS-1:0]     blink_mask,
`endif
   output logic                      load_ack,
   output logic                      A,
   output logic                      B,
   output logic                      C,
   output logic                      D,
   output logic                      E,
   output logic                      F,
   output logic                      G,
   output logic [NUM_DIGITS-1:0]     dig_en,
   output logic                      frame_done
);

   localparam int c_CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
   localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
   localparam int c_IDX_W   = $clog2(NUM_DIGITS);
   localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(DWELL_CYC - 1);
   localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYC - 1);
   localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(NUM_DIGITS - 1);

   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_DWELL = 1'b1;

   if (NUM_DIGITS < 2 || DWELL_CYC < 1 || BLANK_CYC < 1 || BLINK_FRAMES < 1) begin : g_param_check
      $error("seg_scan_ctrl: illegal parameter value");
   end

   logic [0:0]                r_state, w_state_nxt;
   logic [c_CNT_W-1:0]        r_cnt, w_cnt_nxt;
   logic [c_IDX_W-1:0]        r_idx, w_idx_nxt;
   logic                      w_frame_end;
   logic [NUM_DIGITS-1:0]     w_dig_en_nxt;
   logic [6:0]                w_seg_nxt;
   logic [3:0]                w_code;
   logic                      w_hide;
   logic [4*NUM_DIGITS-1:0]   r_shadow, r_pend;
   logic                      r_pend_vld;
   logic [6:0]                r_seg;
   logic [NUM_DIGITS-1:0]     r_dig_en;
   logic                      r_load_ack, r_frame_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_BLANK;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_idx_nxt   = r_idx;
      case (r_state)
         ST_BLANK: begin
            if (r_cnt == c_BLANK_LAST) begin
               w_state_nxt = ST_DWELL;
               w_cnt_nxt   = '0;
            end
         end
         ST_DWELL: begin
            if (r_cnt == c_DWELL_LAST) begin
               w_state_nxt = ST_BLANK;
               w_cnt_nxt   = '0;
               w_idx_nxt   = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
         end
      endcase
   end

   assign w_frame_end = (r_state == ST_DWELL) && (r_cnt == c_DWELL_LAST) && (r_idx == c_IDX_LAST);

`ifdef BLINK_EN
   localparam int c_FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [c_FRM_W-1:0] c_FRM_LAST = c_FRM_W'(BLINK_FRAMES - 1);
   logic [c_FRM_W-1:0] r_frm_cnt;
   logic               r_phase_off;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frm_cnt   <= '0;
         r_phase_off <= 1'b0;
      end else if (w_frame_end) begin
         if (r_frm_cnt == c_FRM_LAST) begin
            r_frm_cnt   <= '0;
            r_phase_off <= ~r_phase_off;
         end else begin
            r_frm_cnt <= r_frm_cnt + 1'b1;
         end
      end
   end
`endif

   // Outputs are registered from the next-state view so dig_en and A..G flip together.
   always_comb begin
      w_dig_en_nxt = '0;
      w_code       = 4'hF;
      w_hide       = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (w_idx_nxt == c_IDX_W'(i)) begin
            w_code = r_shadow[i*4 +: 4];
`ifdef BLINK_EN
            w_hide = r_phase_off & blink_mask[i];
`endif
            if (w_state_nxt == ST_DWELL) begin
               w_dig_en_nxt[i] = 1'b1;
            end
         end
      end
      case (w_code)
         4'h0:    w_seg_nxt = 7'b1111110;
         4'h1:    w_seg_nxt = 7'b0110000;
         4'h2:    w_seg_nxt = 7'b1101101;
         4'h3:    w_seg_nxt = 7'b1111001;
         4'h4:    w_seg_nxt = 7'b0110011;
         4'h5:    w_seg_nxt = 7'b1011011;
         4'h6:    w_seg_nxt = 7'b1011111;
         4'h7:    w_seg_nxt = 7'b1110000;
         4'h8:    w_seg_nxt = 7'b1111111;
         4'h9:    w_seg_nxt = 7'b1111011;
         4'hA:    w_seg_nxt = 7'b1110111;
         4'hB:    w_seg_nxt = 7'b1100111;
         4'hC:    w_seg_nxt = 7'b1110110;
         default: w_seg_nxt = 7'b0000000;
      endcase
      if (w_state_nxt != ST_DWELL || w_hide) begin
         w_seg_nxt = 7'b0000000;
      end
   end

   // A load on the commit cycle bypasses the pending register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shadow     <= '1;
         r_pend       <= '1;
         r_pend_vld   <= 1'b0;
         r_seg        <= '0;
         r_dig_en     <= '0;
         r_load_ack   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_seg        <= w_seg_nxt;
         r_dig_en     <= w_dig_en_nxt;
         r_frame_done <= w_frame_end;
         r_load_ack   <= 1'b0;
         if (w_frame_end && (load || r_pend_vld)) begin
            r_shadow   <= load ? digits_in : r_pend;
            r_pend_vld <= 1'b0;
            r_load_ack <= 1'b1;
         end else if (load) begin
            r_pend     <= digits_in;
            r_pend_vld <= 1'b1;
         end
      end
   end

   assign {A, B, C, D, E, F, G} = r_seg;
   assign dig_en     = r_dig_en;
   assign load_ack   = r_load_ack;
   assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seg_scan_ctrl : directed + random stimulus against a frame-position model |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_seg_scan_ctrl;
   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int BL    = 2;
   localparam int BF    = 2;
   localparam int SLOT  = BL + DW;
   localparam int FRAME = N * SLOT;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] digits_in = '0;
   logic [3:0]  blink_mask = '0;
   logic        load_ack, A, B, C, D, E, F, G, frame_done;
   logic [3:0]  dig_en;

   seg_scan_ctrl #(
      .NUM_DIGITS(N), .DWELL_CYC(DW), .BLANK_CYC(BL), .BLINK_FRAMES(BF)
   ) dut (
      .clk(clk), .rst(rst), .load(load), .digits_in(digits_in),
`ifdef BLINK_EN
      .blink_mask(blink_mask),
`endif
      .load_ack(load_ack), .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
      .dig_en(dig_en), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          t = 0;
   int          acks_seen = 0;
   logic [15:0] m_shadow, m_pend;
   bit          m_pvld, m_ack;
   logic [3:0]  m_prev_mask;

   function automatic logic [6:0] seg_of(input logic [3:0] c);
      case (c)
         4'h0: return 7'b1111110;
         4'h1: return 7'b0110000;
         4'h2: return 7'b1101101;
         4'h3: return 7'b1111001;
         4'h4: return 7'b0110011;
         4'h5: return 7'b1011011;
         4'h6: return 7'b1011111;
         4'h7: return 7'b1110000;
         4'h8: return 7'b1111111;
         4'h9: return 7'b1111011;
         4'hA: return 7'b1110111;
         4'hB: return 7'b1100111;
         4'hC: return 7'b1110110;
         default: return 7'b0000000;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s t=%0d observed %h expected %h", tag, t, got, exp);
      end
   endtask

   task automatic model_reset();
      m_shadow    = 16'hFFFF;
      m_pend      = 16'hFFFF;
      m_pvld      = 1'b0;
      m_ack       = 1'b0;
      m_prev_mask = blink_mask;
      t           = 0;
   endtask

   // Expected outputs follow directly from the position inside the frame.
   task automatic check_now();
      int         p, slot;
      bit         dw, hide;
      logic [3:0] exp_en;
      logic [6:0] exp_seg;
      p      = t % FRAME;
      slot   = p / SLOT;
      dw     = (p % SLOT) >= BL;
      exp_en = dw ? 4'(1 << slot) : 4'b0000;
      hide   = 1'b0;
`ifdef BLINK_EN
      hide   = m_prev_mask[slot] && (((t / FRAME) / BF) % 2 == 1);
`endif
      exp_seg = (dw && !hide) ? seg_of(m_shadow[slot*4 +: 4]) : 7'b0000000;
      chk("dig_en", 16'(dig_en), 16'(exp_en));
      chk("segs", 16'({A, B, C, D, E, F, G}), 16'(exp_seg));
      chk("frame_done", 16'(frame_done), 16'(t > 0 && p == 0));
      chk("load_ack", 16'(load_ack), 16'(m_ack));
   endtask

   task automatic consume();
      if (load_ack === 1'b1) acks_seen++;
      if (t % FRAME == FRAME - 1) begin
         m_ack = load || m_pvld;
         if (load) m_shadow = digits_in;
         else if (m_pvld) m_shadow = m_pend;
         m_pvld = 1'b0;
      end else begin
         m_ack = 1'b0;
         if (load) begin
            m_pend = digits_in;
            m_pvld = 1'b1;
         end
      end
      m_prev_mask = blink_mask;
   endtask

   task automatic step();
      check_now();
      consume();
      @(posedge clk);
      @(negedge clk);
      t++;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic run_to(input int pos);
      for (int k = 0; k < FRAME && (t % FRAME) != pos; k++) step();
   endtask

   task automatic pulse_load(input logic [15:0] d);
      digits_in = d;
      load      = 1'b1;
      step();
      load      = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_dig_en", 16'(dig_en), 16'h0);
      chk("rst_segs", 16'({A, B, C, D, E, F, G}), 16'h0);
      chk("rst_ack", 16'(load_ack), 16'h0);
      chk("rst_fd", 16'(frame_done), 16'h0);
      rst = 1'b0;
      model_reset();

      // Blank content after reset
      run(2 * FRAME);

      // Mid-frame load, committed at the boundary
      run_to(15);
      pulse_load(16'h1234);
      run_to(BL);
      step();
      chk("digit0_is_4", 16'({A, B, C, D, E, F, G}), 16'(7'b0110011));
      run(FRAME);

      // Latest of two loads wins, one ack
      run_to(5);
      acks_seen = 0;
      pulse_load(16'h0000);
      run(3);
      pulse_load(16'h9999);
      run_to(BL + 1);
      chk("one_ack", 16'(acks_seen), 16'd1);
      chk("digit0_is_9", 16'({A, B, C, D, E, F, G}), 16'(7'b1111011));

      // Load exactly on the commit cycle
      run_to(FRAME - 1);
      pulse_load(16'hBA00);
      run_to(2 * SLOT + BL);
      step();
      chk("digit2_is_A", 16'({A, B, C, D, E, F, G}), 16'(7'b1110111));
      run_to(3 * SLOT + BL);
      step();
      chk("digit3_is_P", 16'({A, B, C, D, E, F, G}), 16'(7'b1100111));

      // Async reset in the middle of digit 2's dwell
      run_to(2 * SLOT + BL + 3);
      rst = 1'b1;
      #1;
      chk("async_dig_en", 16'(dig_en), 16'h0);
      chk("async_segs", 16'({A, B, C, D, E, F, G}), 16'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      run(FRAME + 5);

      // Blink pattern on digit 0
      blink_mask = 4'b0001;
      pulse_load(16'h8888);
      run(5 * FRAME);

      // Random traffic
      for (int k = 0; k < 1200; k++) begin
         load       = ($urandom % 8) == 0;
         digits_in  = 16'($urandom);
         blink_mask = 4'($urandom);
         step();
      end
      load = 1'b0;
      run(FRAME);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
